// File: rtl/memoria_instrucciones.sv
// Dual-read-port instruction memory with a byte-stream program loader.
// The loader assembles little-endian 32-bit words while in LOAD; fetch reads
// are serviced only in RUN, with one cycle of registered latency per port.
module memoria_instrucciones #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h00400000,
  parameter logic [31:0] NOP_WORD    = 32'h00000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ReadMem_1,
  input  logic [31:0]                   Dir_Instru_1,
  output logic [31:0]                   Dato_Instru_1,
  output logic                          Valid_1,
  output logic                          Err_1,
  input  logic                          ReadMem_2,
  input  logic [31:0]                   Dir_Instru_2,
  output logic [31:0]                   Dato_Instru_2,
  output logic                          Valid_2,
  output logic                          Err_2,
  input  logic                          load_start,
  input  logic                          load_valid,
  input  logic [7:0]                    load_byte,
  input  logic                          load_done,
  output logic                          load_ready,
  output logic                          busy,
  output logic [$clog2(DEPTH_WORDS):0]  words_loaded
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] DEPTH_CNT = DEPTH_WORDS[AW:0];

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t         state_q, state_d;
  logic [AW:0]    ptr_q, ptr_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    asm_q, asm_d;
  logic [31:0]    asm_inc;
  logic           accept;

  logic           we;
  logic [AW-1:0]  waddr;
  logic [31:0]    wdata;
  logic [31:0]    mem [DEPTH_WORDS];

  logic [1:0]         rd_req;
  logic [1:0][31:0]   dir;
  logic [1:0][31:0]   off;
  logic [1:0][31:0]   idx_full;
  logic [1:0]         bad;
  logic [1:0][31:0]   dato_q, dato_d;
  logic [1:0]         valid_q, valid_d;
  logic [1:0]         err_q, err_d;

  assign rd_req = {ReadMem_2, ReadMem_1};
  assign dir    = {Dir_Instru_2, Dir_Instru_1};

  // Loader FSM: byte assembly, word writes, LOAD/RUN transitions.
  // words_loaded always equals the write pointer, so no separate counter is kept.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    we         = 1'b0;
    waddr      = ptr_q[AW-1:0];
    wdata      = asm_q;
    accept     = 1'b0;
    asm_inc    = asm_q;
    busy       = (state_q == ST_LOAD);
    load_ready = (state_q == ST_LOAD) && (ptr_q < DEPTH_CNT);
    case (state_q)
      ST_LOAD: begin
        if (load_start) begin
          ptr_d = '0;
          cnt_d = '0;
          asm_d = '0;
        end else begin
          accept = load_valid && load_ready;
          asm_inc[{cnt_q, 3'b000} +: 8] = load_byte;
          if (accept) begin
            if (cnt_q == 2'd3) begin
              we    = 1'b1;
              wdata = asm_inc;
              ptr_d = ptr_q + 1'b1;
              cnt_d = '0;
              asm_d = '0;
            end else begin
              cnt_d = cnt_q + 2'd1;
              asm_d = asm_inc;
            end
          end
          // Partial word: upper bytes of asm are still zero from the last clear.
          if (load_done) begin
            if (cnt_d != 2'd0) begin
              we    = 1'b1;
              wdata = asm_d;
              ptr_d = ptr_q + 1'b1;
            end
            cnt_d   = '0;
            asm_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          asm_d   = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Per-port read decode: address validation and next output values.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      dato_d[p]   = dato_q[p];
      valid_d[p]  = 1'b0;
      err_d[p]    = err_q[p];
      off[p]      = dir[p] - BASE_ADDR;
      idx_full[p] = {2'b00, off[p][31:2]};
      bad[p]      = (dir[p][1:0] != 2'b00) || (dir[p] < BASE_ADDR) ||
                    (idx_full[p] >= 32'(ptr_q));
      if (rd_req[p]) begin
        if (state_q == ST_LOAD) begin
          dato_d[p] = NOP_WORD;
          err_d[p]  = 1'b0;
        end else begin
          valid_d[p] = 1'b1;
          if (bad[p]) begin
            dato_d[p] = NOP_WORD;
            err_d[p]  = 1'b1;
          end else begin
            dato_d[p] = mem[off[p][AW+1:2]];
            err_d[p]  = 1'b0;
          end
        end
      end
    end
  end

  // State, loader and read-output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      dato_q  <= {2{NOP_WORD}};
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      dato_q  <= dato_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Program array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem[waddr] <= wdata;
    end
  end

  assign Dato_Instru_1 = dato_q[0];
  assign Dato_Instru_2 = dato_q[1];
  assign Valid_1       = valid_q[0];
  assign Valid_2       = valid_q[1];
  assign Err_1         = err_q[0];
  assign Err_2         = err_q[1];
  assign words_loaded  = ptr_q;

endmodule
